// File: rtl/axis_stereo_unpack.sv
// axis_stereo_unpack: assembles a serial stream of L/R sample beats into
// aligned stereo pairs. A missing left (orphan right) or a repeated left
// counts as one alignment error. The block then resynchronises to the next
// left beat, and a repeated left keeps the newest value.
module axis_stereo_unpack #(
  parameter int width_p     = 24,
  parameter int err_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   last_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [width_p-1:0]     data_left_o,
  output logic [width_p-1:0]     data_right_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   err_o,
  output logic [err_width_p-1:0] err_count_o
);

  typedef enum logic [1:0] {
    WAIT_L = 2'd0,
    WAIT_R = 2'd1,
    FULL   = 2'd2
  } state_t;

  typedef struct packed {
    logic [width_p-1:0] left;
    logic [width_p-1:0] right;
  } pair_t;

  localparam logic [err_width_p-1:0] ERR_MAX = '1;

  state_t             state, state_nxt;
  logic               accept;
  logic               load_left;
  logic               load_pair;
  logic               err_evt;
  logic [width_p-1:0] left_hold;
  pair_t              pair;

  // Handshake flags come straight from the state register, so ready_o has
  // no combinational path from ready_i.
  assign ready_o      = (state != FULL);
  assign valid_o      = (state == FULL);
  assign accept       = valid_i & ready_o;
  assign data_left_o  = pair.left;
  assign data_right_o = pair.right;

  // Next-state and datapath strobes; an error never moves the FSM forward.
  always_comb begin
    state_nxt = state;
    load_left = 1'b0;
    load_pair = 1'b0;
    err_evt   = 1'b0;
    case (state)
      WAIT_L: begin
        if (accept) begin
          if (last_i) begin
            err_evt = 1'b1;              // orphan right: drop it
          end else begin
            load_left = 1'b1;
            state_nxt = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (accept) begin
          if (last_i) begin
            load_pair = 1'b1;
            state_nxt = FULL;
          end else begin
            load_left = 1'b1;            // duplicate left: newest wins
            err_evt   = 1'b1;
          end
        end
      end
      FULL: begin
        if (ready_i) state_nxt = WAIT_L;
      end
      default: state_nxt = WAIT_L;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= WAIT_L;
    else         state <= state_nxt;
  end

  // Left holding register and output pair. The pair only loads on entry to
  // FULL, so it stays stable for as long as the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      left_hold <= '0;
      pair      <= '0;
    end else begin
      if (load_left) left_hold <= data_i;
      if (load_pair) pair      <= '{left: left_hold, right: data_i};
    end
  end

  // Error pulse (one cycle after the offending beat) and saturating count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_o       <= 1'b0;
      err_count_o <= '0;
    end else begin
      err_o <= err_evt;
      if (err_evt && (err_count_o != ERR_MAX)) err_count_o <= err_count_o + 1'b1;
    end
  end

endmodule
